// File: rtl/tune_scan_ctrl.sv
// Band scanner: steps the NCO across channels, settles, averages RSSI and stops
// on the first channel whose average reaches threshold, else restores the origin.
module tune_scan_ctrl #(
    parameter int LOW_FREQ_KHZ  = 500,
    parameter int HIGH_FREQ_KHZ = 1700,
    parameter int FREQ_STEP_KHZ = 10,
    parameter int FREQ_SIZE     = 12,
    parameter int SETTLE_CYCLES = 4096,
    parameter int AVG_LOG2      = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [FREQ_SIZE-1:0] start_freq,
    input  logic [31:0]          start_phi,
    input  logic                 scan_req,
    input  logic                 scan_dir,
    input  logic                 abort,
    input  logic [15:0]          rssi,
    input  logic                 rssi_vld,
    input  logic [15:0]          threshold,
    input  logic                 nco_ack,
    output logic                 nco_load,
    output logic [FREQ_SIZE-1:0] freq,
    output logic [31:0]          phi_inc,
    output logic                 busy,
    output logic                 lock_strb,
    output logic                 nolock_strb
);

    // Phase increment for a kHz value, rounded to nearest.
    localparam logic [31:0] LOW_PH  = 32'((((64'(LOW_FREQ_KHZ)  * 64'd879609302) >> 10) + 64'd1) >> 1);
    localparam logic [31:0] HIGH_PH = 32'((((64'(HIGH_FREQ_KHZ) * 64'd879609302) >> 10) + 64'd1) >> 1);
    localparam logic [31:0] STEP_PH = 32'((((64'(FREQ_STEP_KHZ) * 64'd879609302) >> 10) + 64'd1) >> 1);

    localparam logic [FREQ_SIZE-1:0] LOW_F  = FREQ_SIZE'(LOW_FREQ_KHZ);
    localparam logic [FREQ_SIZE-1:0] HIGH_F = FREQ_SIZE'(HIGH_FREQ_KHZ);
    localparam logic [FREQ_SIZE-1:0] STEP_F = FREQ_SIZE'(FREQ_STEP_KHZ);

    localparam int NCH   = (HIGH_FREQ_KHZ - LOW_FREQ_KHZ) / FREQ_STEP_KHZ + 1;
    localparam int CH_W  = $clog2(NCH + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int ACC_W = 16 + AVG_LOG2;

    localparam logic [CH_W-1:0]  NCH_C    = CH_W'(NCH);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, STEP, LOAD, SETTLE, MEASURE, DECIDE} state_t;

    state_t               state_q, state_d;
    logic [FREQ_SIZE-1:0] freq_q, freq_d, org_freq_q, org_freq_d;
    logic [31:0]          phi_q, phi_d, org_phi_q, org_phi_d;
    logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d;
    logic [SET_W-1:0]     set_cnt_q, set_cnt_d;
    logic [SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 nco_load_q, nco_load_d;
    logic                 lock_q, lock_d, nolock_q, nolock_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 restore_q, restore_d;
    logic [15:0]          avg;

    assign avg = acc_q[ACC_W-1:AVG_LOG2];

    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        phi_d        = phi_q;
        org_freq_d   = org_freq_q;
        org_phi_d    = org_phi_q;
        ch_cnt_d     = ch_cnt_q;
        set_cnt_d    = set_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        acc_d        = acc_q;
        nco_load_d   = 1'b0;
        lock_d       = 1'b0;
        nolock_d     = 1'b0;
        abort_pend_d = abort_pend_q;
        restore_d    = restore_q;
        case (state_q)
            IDLE: begin
                if (scan_req && !abort) begin
                    org_freq_d   = start_freq;
                    org_phi_d    = start_phi;
                    freq_d       = start_freq;
                    phi_d        = start_phi;
                    ch_cnt_d     = '0;
                    abort_pend_d = 1'b0;
                    restore_d    = 1'b0;
                    state_d      = STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (!scan_dir) begin
                        if (freq_q >= HIGH_F) begin
                            freq_d = LOW_F;
                            phi_d  = LOW_PH;
                        end else begin
                            freq_d = freq_q + STEP_F;
                            phi_d  = phi_q + STEP_PH;
                        end
                    end else begin
                        if (freq_q <= LOW_F) begin
                            freq_d = HIGH_F;
                            phi_d  = HIGH_PH;
                        end else begin
                            freq_d = freq_q - STEP_F;
                            phi_d  = phi_q - STEP_PH;
                        end
                    end
                    ch_cnt_d = ch_cnt_q + 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                // An abort here must not strand the NCO mid-handshake.
                if (abort) abort_pend_d = 1'b1;
                if (!nco_load_q) begin
                    nco_load_d = 1'b1;
                end else if (!nco_ack) begin
                    nco_load_d = 1'b1;
                end else begin
                    set_cnt_d = '0;
                    if (abort || abort_pend_q) begin
                        state_d = IDLE;
                    end else if (restore_q) begin
                        nolock_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (set_cnt_q == SET_LAST) begin
                    acc_d     = '0;
                    smp_cnt_d = '0;
                    state_d   = MEASURE;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rssi_vld) begin
                    acc_d     = acc_q + ACC_W'(rssi);
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == SMP_LAST) state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (avg >= threshold) begin
                    lock_d  = 1'b1;
                    state_d = IDLE;
                end else if (ch_cnt_q < NCH_C) begin
                    state_d = STEP;
                end else begin
                    freq_d    = org_freq_q;
                    phi_d     = org_phi_q;
                    restore_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            freq_q       <= LOW_F;
            phi_q        <= LOW_PH;
            org_freq_q   <= LOW_F;
            org_phi_q    <= LOW_PH;
            ch_cnt_q     <= '0;
            set_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            nco_load_q   <= 1'b0;
            lock_q       <= 1'b0;
            nolock_q     <= 1'b0;
            abort_pend_q <= 1'b0;
            restore_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            phi_q        <= phi_d;
            org_freq_q   <= org_freq_d;
            org_phi_q    <= org_phi_d;
            ch_cnt_q     <= ch_cnt_d;
            set_cnt_q    <= set_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            acc_q        <= acc_d;
            nco_load_q   <= nco_load_d;
            lock_q       <= lock_d;
            nolock_q     <= nolock_d;
            abort_pend_q <= abort_pend_d;
            restore_q    <= restore_d;
        end
    end

    assign nco_load    = nco_load_q;
    assign freq        = freq_q;
    assign phi_inc     = phi_q;
    assign busy        = (state_q != IDLE);
    assign lock_strb   = lock_q;
    assign nolock_strb = nolock_q;

endmodule

// File: tb/tb_tune_scan_ctrl.sv
// Directed bench for tune_scan_ctrl with a short settle time; an NCO responder
// acks after a programmable delay and a monitor tallies loads and strobes.
module tb_tune_scan_ctrl;

    localparam int ST = 16;
    localparam logic [31:0] LOW_PH  = 32'd214748365;
    localparam logic [31:0] HIGH_PH = 32'd730144440;
    localparam logic [31:0] STEP_PH = 32'd4294967;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] start_freq = '0;
    logic [31:0] start_phi = '0;
    logic        scan_req = 1'b0, scan_dir = 1'b0, abort = 1'b0;
    logic [15:0] rssi = '0;
    logic        rssi_vld = 1'b1;
    logic [15:0] threshold = '0;
    logic        nco_ack = 1'b0;
    logic        nco_load, busy, lock_strb, nolock_strb;
    logic [11:0] freq;
    logic [31:0] phi_inc;

    int errs = 0, checks = 0;
    int ack_dly = 1;
    logic [15:0] rssi_base = '0;
    logic alt_mode = 1'b0;

    int n_loads, n_lock, n_nolock, n_both, hi_run, last_run;
    logic [11:0] f1, last_f, prev_f;
    logic [31:0] p1;

    tune_scan_ctrl #(.SETTLE_CYCLES(ST)) dut (
        .clk(clk), .reset_n(reset_n), .start_freq(start_freq), .start_phi(start_phi),
        .scan_req(scan_req), .scan_dir(scan_dir), .abort(abort), .rssi(rssi),
        .rssi_vld(rssi_vld), .threshold(threshold), .nco_ack(nco_ack),
        .nco_load(nco_load), .freq(freq), .phi_inc(phi_inc), .busy(busy),
        .lock_strb(lock_strb), .nolock_strb(nolock_strb)
    );

    always #5 clk = ~clk;

    // NCO model: ack in the ack_dly-th cycle that nco_load is seen high
    initial begin : ack_resp
        int run;
        run = 0;
        forever begin
            @(posedge clk); #1;
            if (nco_load) run++; else run = 0;
            nco_ack = nco_load && (run >= ack_dly);
        end
    end

    initial begin : rssi_gen
        logic tog;
        tog = 1'b0;
        forever begin
            @(posedge clk); #1;
            rssi = rssi_base + (alt_mode ? 16'(tog) : 16'd0);
            tog  = ~tog;
        end
    end

    always @(negedge clk) begin
        if (nco_load && nco_ack) begin
            n_loads++;
            if (n_loads == 1) begin f1 = freq; p1 = phi_inc; end
            prev_f = last_f;
            last_f = freq;
        end
        if (nco_load) hi_run++;
        else begin
            if (hi_run != 0) last_run = hi_run;
            hi_run = 0;
        end
        if (lock_strb) n_lock++;
        if (nolock_strb) n_nolock++;
        if (lock_strb && nolock_strb) n_both++;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        n_loads = 0; n_lock = 0; n_nolock = 0; hi_run = 0; last_run = 0;
        f1 = '0; p1 = '0; last_f = '0; prev_f = '0;
    endtask

    task automatic start_scan(input logic [11:0] f, input logic [31:0] p, input logic d);
        start_freq = f; start_phi = p; scan_dir = d; scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin tick(); n++; end
        checks++;
        if (busy) begin errs++; $display("FAIL idle_timeout: busy=%0d after %0d cycles, want 0", busy, n); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        n_both = 0;
        clear_mon();
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (nco_load !== 1'b0) begin errs++; $display("FAIL rst_load: got %0b want 0", nco_load); end
        checks++; if (freq !== 12'd500) begin errs++; $display("FAIL rst_freq: got %0d want 500", freq); end
        checks++; if (phi_inc !== LOW_PH) begin errs++; $display("FAIL rst_phi: got %0d want %0d", phi_inc, LOW_PH); end
        checks++; if ({lock_strb, nolock_strb} !== 2'b00) begin errs++; $display("FAIL rst_strb: got %b want 00", {lock_strb, nolock_strb}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lock_up();
        int cyc;
        ack_dly = 1; threshold = 16'd0; rssi_base = 16'd5; alt_mode = 1'b0;
        clear_mon();
        start_scan(12'd500, LOW_PH, 1'b0);
        cyc = 1;
        while (!lock_strb && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc != ST + 21) begin errs++; $display("FAIL lock_latency: got %0d want %0d", cyc, ST + 21); end
        tick();
        checks++; if (freq !== 12'd510) begin errs++; $display("FAIL up_freq: got %0d want 510", freq); end
        checks++; if (phi_inc !== 32'd219043332) begin errs++; $display("FAIL up_phi: got %0d want 219043332", phi_inc); end
        checks++; if (n_loads != 1 || last_run != 1) begin errs++; $display("FAIL up_loads: got loads=%0d run=%0d want 1/1", n_loads, last_run); end
        checks++; if (n_lock != 1 || n_nolock != 0) begin errs++; $display("FAIL up_strb: got lock=%0d nolock=%0d want 1/0", n_lock, n_nolock); end
    endtask

    task automatic test_wrap();
        threshold = 16'd0; ack_dly = 1;
        clear_mon();
        start_scan(12'd500, LOW_PH, 1'b1);
        wait_idle(200);
        checks++; if (freq !== 12'd1700 || phi_inc !== HIGH_PH) begin errs++; $display("FAIL down_wrap: got %0d/%0d want 1700/%0d", freq, phi_inc, HIGH_PH); end
        clear_mon();
        start_scan(12'd2000, 32'd0, 1'b0);
        wait_idle(200);
        checks++; if (freq !== 12'd500 || phi_inc !== LOW_PH) begin errs++; $display("FAIL oob_wrap: got %0d/%0d want 500/%0d", freq, phi_inc, LOW_PH); end
        checks++; if (n_lock != 1) begin errs++; $display("FAIL oob_lock: got %0d want 1", n_lock); end
    endtask

    task automatic test_ack_delay();
        int cyc;
        ack_dly = 7; threshold = 16'd0;
        clear_mon();
        start_scan(12'd600, 32'd1000, 1'b0);
        cyc = 1;
        while (!lock_strb && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc != ST + 27) begin errs++; $display("FAIL ackdly_latency: got %0d want %0d", cyc, ST + 27); end
        checks++; if (last_run != 7) begin errs++; $display("FAIL ackdly_run: got %0d want 7", last_run); end
        checks++; if (freq !== 12'd610 || phi_inc !== 32'd1000 + STEP_PH) begin errs++; $display("FAIL ackdly_val: got %0d/%0d want 610/%0d", freq, phi_inc, 32'd1000 + STEP_PH); end
        tick();
    endtask

    task automatic test_threshold();
        int n;
        ack_dly = 1; alt_mode = 1'b1; rssi_base = 16'd100;
        threshold = 16'd100;
        clear_mon();
        start_scan(12'd500, LOW_PH, 1'b0);
        wait_idle(200);
        checks++; if (n_lock != 1 || freq !== 12'd510) begin errs++; $display("FAIL thr_equal: got lock=%0d freq=%0d want 1/510", n_lock, freq); end
        // average truncates to 100, one below threshold: scan moves on
        threshold = 16'd101;
        clear_mon();
        start_scan(12'd500, LOW_PH, 1'b0);
        n = 0;
        while (n_loads < 2 && n < 300) begin tick(); n++; end
        checks++; if (n_loads != 2) begin errs++; $display("FAIL thr_trunc: got loads=%0d want 2", n_loads); end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL settle_abort_busy: got %0b want 0", busy); end
        checks++; if (freq !== 12'd520) begin errs++; $display("FAIL settle_abort_freq: got %0d want 520", freq); end
        repeat (3) tick();
        checks++; if (n_lock != 0 || n_nolock != 0) begin errs++; $display("FAIL settle_abort_strb: got %0d/%0d want 0/0", n_lock, n_nolock); end
        alt_mode = 1'b0;
    endtask

    task automatic test_abort_load();
        int n;
        ack_dly = 7; threshold = 16'd0;
        clear_mon();
        start_scan(12'd800, 32'd0, 1'b0);
        n = 0;
        while (!nco_load && n < 20) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n = 0;
        while (nco_load && n < 20) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL load_abort_busy: got %0b want 0", busy); end
        checks++; if (last_run != 7 || n_loads != 1) begin errs++; $display("FAIL load_abort_hs: got run=%0d loads=%0d want 7/1", last_run, n_loads); end
        checks++; if (freq !== 12'd810) begin errs++; $display("FAIL load_abort_freq: got %0d want 810", freq); end
        repeat (ST + 30) tick();
        checks++; if (n_lock != 0 || busy !== 1'b0) begin errs++; $display("FAIL load_abort_strb: got lock=%0d busy=%0b want 0/0", n_lock, busy); end
    endtask

    task automatic test_abort_same();
        ack_dly = 1;
        clear_mon();
        start_freq = 12'd900; scan_req = 1'b1; abort = 1'b1;
        tick();
        scan_req = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL req_abort_busy: got %0b want 0", busy); end
        repeat (4) tick();
        checks++; if (n_loads != 0 || freq !== 12'd810) begin errs++; $display("FAIL req_abort_idle: got loads=%0d freq=%0d want 0/810", n_loads, freq); end
    endtask

    task automatic test_sweep_nolock();
        ack_dly = 1; rssi_base = 16'd100; threshold = 16'd200;
        clear_mon();
        start_scan(12'd1700, HIGH_PH, 1'b0);
        wait_idle(8000);
        tick();
        checks++; if (f1 !== 12'd500 || p1 !== LOW_PH) begin errs++; $display("FAIL sweep_first: got %0d/%0d want 500/%0d", f1, p1, LOW_PH); end
        checks++; if (n_loads != 122) begin errs++; $display("FAIL sweep_loads: got %0d want 122", n_loads); end
        checks++; if (prev_f !== 12'd1700 || last_f !== 12'd1700) begin errs++; $display("FAIL sweep_last: got %0d,%0d want 1700,1700", prev_f, last_f); end
        checks++; if (n_nolock != 1 || n_lock != 0) begin errs++; $display("FAIL sweep_strb: got nolock=%0d lock=%0d want 1/0", n_nolock, n_lock); end
        checks++; if (freq !== 12'd1700 || phi_inc !== HIGH_PH) begin errs++; $display("FAIL sweep_restore: got %0d/%0d want 1700/%0d", freq, phi_inc, HIGH_PH); end
    endtask

    task automatic test_max_rssi_reset();
        ack_dly = 1; rssi_base = 16'hFFFF; threshold = 16'hFFFF;
        clear_mon();
        start_scan(12'd1000, 32'd0, 1'b0);
        wait_idle(200);
        checks++; if (n_lock != 1 || freq !== 12'd1010) begin errs++; $display("FAIL max_lock: got lock=%0d freq=%0d want 1/1010", n_lock, freq); end
        start_scan(12'd1000, 32'd0, 1'b0);
        repeat (ST + 8) tick();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL meas_busy: got %0b want 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || nco_load !== 1'b0 || {lock_strb, nolock_strb} !== 2'b00) begin
            errs++; $display("FAIL meas_rst_ctl: got busy=%0b load=%0b strb=%b want 0/0/00", busy, nco_load, {lock_strb, nolock_strb}); end
        checks++; if (freq !== 12'd500 || phi_inc !== LOW_PH) begin errs++; $display("FAIL meas_rst_freq: got %0d/%0d want 500/%0d", freq, phi_inc, LOW_PH); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_wrap();
        test_ack_delay();
        test_threshold();
        test_abort_load();
        test_abort_same();
        test_sweep_nolock();
        test_max_rssi_reset();
        checks++; if (n_both != 0) begin errs++; $display("FAIL both_strobes: got %0d want 0", n_both); end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
